// File: rtl/nrisc_ula_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier that borrows the shared ULA;
// core operands pass straight through to the ULA whenever the sequencer is idle.
module nrisc_ula_mul_seq #(
  parameter int TAM = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [TAM-1:0] op_a_i,
  input  logic [TAM-1:0] op_b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [TAM-1:0] result_o,
  output logic           overflow_o,
  output logic           cpu_stall_o,
  input  logic [TAM-1:0] cpu_a_i,
  input  logic [TAM-1:0] cpu_b_i,
  input  logic [3:0]     cpu_ctrl_i,
  output logic [TAM-1:0] ula_a_o,
  output logic [TAM-1:0] ula_b_o,
  output logic [3:0]     ula_ctrl_o,
  input  logic [TAM-1:0] ula_out_i,
  input  logic [2:0]     ula_flags_i
);

  localparam logic [3:0] CTRL_ADD = 4'b0000;
  localparam logic [3:0] CTRL_SHL = 4'b1100;
  localparam logic [3:0] CTRL_SHR = 4'b1000;
  localparam logic [TAM-1:0] ONE = {{(TAM-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [TAM-1:0] acc_q, acc_d;
  logic [TAM-1:0] mcand_q, mcand_d;
  logic [TAM-1:0] mplier_q, mplier_d;
  logic           ovf_q, ovf_d;
  logic [TAM-1:0] result_q, result_d;
  logic           overflow_q, overflow_d;

  // Flags are deliberately ignored; sequencing relies on ula_out alone.
  logic unused_flags;
  assign unused_flags = ^ula_flags_i;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    ula_a_o    = cpu_a_i;
    ula_b_o    = cpu_b_i;
    ula_ctrl_o = cpu_ctrl_i;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          acc_d    = '0;
          mcand_d  = op_a_i;
          mplier_d = op_b_i;
          ovf_d    = 1'b0;
          if (op_b_i == '0) begin
            // Zero multiplier: the product is known now, so publish it on this entry.
            state_d    = S_DONE;
            result_d   = '0;
            overflow_d = 1'b0;
          end else if (op_b_i[0]) begin
            state_d = S_ADD;
          end else begin
            state_d = S_SHL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADD: begin
        ula_a_o    = acc_q;
        ula_b_o    = mcand_q;
        ula_ctrl_o = CTRL_ADD;
        acc_d      = ula_out_i;
        if (ula_out_i < acc_q) ovf_d = 1'b1;
        state_d    = S_SHL;
      end

      S_SHL: begin
        ula_a_o    = mcand_q;
        ula_b_o    = ONE;
        ula_ctrl_o = CTRL_SHL;
        mcand_d    = ula_out_i;
        // A bit shifted out only matters if a higher multiplier bit will still use it.
        if (mcand_q[TAM-1] && (mplier_q[TAM-1:1] != '0)) ovf_d = 1'b1;
        state_d    = S_SHR;
      end

      S_SHR: begin
        ula_a_o    = mplier_q;
        ula_b_o    = ONE;
        ula_ctrl_o = CTRL_SHR;
        mplier_d   = ula_out_i;
        if (ula_out_i == '0) begin
          state_d    = S_DONE;
          result_d   = acc_q;
          overflow_d = ovf_q;
        end else if (ula_out_i[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHL;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy_o      = (state_q == S_ADD) || (state_q == S_SHL) || (state_q == S_SHR);
  assign done_o      = (state_q == S_DONE);
  assign cpu_stall_o = busy_o;
  assign result_o    = result_q;
  assign overflow_o  = overflow_q;

endmodule
